delay_timer: RTL and testbench
==============================

Name: delay_timer

Overview:
Parametrised programmable delay/interval timer. It generalises the team's fixed 2 ms delay generator: run-time delay length, one-shot or periodic mode, a clock prescaler, and busy/level status. FSM-driven peripherals use it for power-up waits, sensor settle times and periodic sampling strobes, all on the 100 MHz system clock.

Parameters:
CNT_WIDTH, 18, width of the tick counter and of delay_ticks
PRESCALE, 1, clock cycles per timer tick (integer, 1 or more; 1 means no prescaling)

Ports:
clock  input  1  system clock (100 MHz); all logic is on its rising edge
reset_n  input  1  asynchronous, active-low reset
en_delay  input  1  level enable; high requests or continues a run, low aborts
periodic  input  1  0 = one-shot, 1 = auto-reload; sampled when a run starts
delay_ticks  input  CNT_WIDTH  delay length N in ticks; sampled at run start and at each periodic reload
delay_done  output  1  one-cycle pulse when N ticks have elapsed
done_level  output  1  held high after a one-shot completes, until en_delay falls
busy  output  1  high while in the RUN state

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; count, prescaler and latched N all 0; delay_done, done_level and busy all 0. Reset mid-run discards the run and produces no pulse.
- Internal registers: count[CNT_WIDTH-1:0], pre (0 to PRESCALE-1), n_lat, mode_lat.
- tick is high when pre == PRESCALE-1. pre increments every RUN cycle and wraps to 0 on tick. With PRESCALE=1, tick is high every RUN cycle.
- States: IDLE, RUN, DONE.
- IDLE: when en_delay is high at edge e0, go to RUN. Set count=0 and pre=0. Latch n_lat = max(delay_ticks,1), so N=0 is treated as 1. Latch mode_lat = periodic.
- RUN: busy=1. On tick, count increments.
- RUN, terminal tick (tick with count == n_lat-1):
  - delay_done=1 for exactly one cycle; count resets to 0.
  - If mode_lat=1: stay in RUN and reload n_lat from delay_ticks (0 treated as 1).
  - If mode_lat=0: go to DONE.
- Latency: the first delay_done is high in the cycle after edge e0 + N*PRESCALE. Periodic runs then pulse exactly every N*PRESCALE cycles.
- DONE: busy=0, done_level=1, no further pulses. When en_delay is low, go to IDLE and clear done_level. A new one-shot needs en_delay to go low and then high again.
- Abort: en_delay low in RUN means the next state is IDLE, with count and pre cleared. No delay_done is produced, even if that same edge is the terminal tick; abort takes priority.
- Changes to periodic or delay_ticks while in RUN have no effect until the next latch point.
- Count arithmetic is unsigned. n_lat-1 never underflows because n_lat is at least 1. A delay_ticks value of all-ones is legal.
- delay_done, done_level and busy are registered outputs with no combinational input-to-output paths.
- Legacy equivalence: periodic=1, delay_ticks=200001, PRESCALE=1 gives one pulse every 200001 cycles while en_delay is high.

Optional Feature:
Macro DELAY_REMAIN_EN.
- Defined: adds output port remaining, CNT_WIDTH bits, registered.
  - In RUN it equals n_lat-1-count.
  - It is 0 in IDLE, in DONE and in reset.
  - On the cycle delay_done is high it shows the reloaded value for periodic runs, and 0 for one-shot.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Hold reset_n low, toggle en_delay -> all outputs stay 0. Release reset_n, keep en_delay low for 10 cycles -> still 0.
2. PRESCALE=1, N=5, periodic=0, en_delay high at edge e0 -> busy high from e0. delay_done is a single pulse after e0+5, with done_level=1 and busy=0 after it. Holding en_delay high gives no second pulse. en_delay low -> done_level=0 on the next edge.
3. PRESCALE=1, N=3, periodic=1, en_delay held 12 cycles -> pulses after e0+3, +6, +9, +12. Change delay_ticks to 2 after the first pulse -> following pulses are 2 cycles apart.
4. N=4, periodic=0, drop en_delay at e0+3 -> no delay_done, state IDLE, busy=0. Dropping it at the terminal edge e0+4 also gives no pulse.
5. N=0 -> treated as 1, pulse after e0+1. PRESCALE=4, N=2 -> pulse after e0+8.
6. Assert reset_n low asynchronously mid-cycle during RUN at count=2 -> all outputs 0 immediately. With DELAY_REMAIN_EN defined, remaining goes to 0; with N=5, remaining steps 4,3,2,1,0 during the run.

Source files
------------

// File: rtl/delay_timer.sv
// Programmable delay/interval timer: one-shot or periodic, with clock prescaler and busy/done status.
// Optional DELAY_REMAIN_EN macro adds a registered "remaining ticks" output.
module delay_timer #(
    parameter int CNT_WIDTH = 18,
    parameter int PRESCALE  = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 en_delay,
    input  logic                 periodic,
    input  logic [CNT_WIDTH-1:0] delay_ticks,
    output logic                 delay_done,
    output logic                 done_level,
`ifdef DELAY_REMAIN_EN
    output logic [CNT_WIDTH-1:0] remaining,
`endif
    output logic                 busy
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [CNT_WIDTH-1:0]   r_count;
    logic [PW-1:0]          r_pre;
    logic [CNT_WIDTH-1:0]   r_n_lat;
    logic                   r_mode_lat;
    logic                   r_delay_done;
    logic                   r_done_level;
    logic                   r_busy;
`ifdef DELAY_REMAIN_EN
    logic [CNT_WIDTH-1:0]   r_remaining;
`endif

    logic                   w_tick;
    logic                   w_last;
    logic [CNT_WIDTH-1:0]   w_n_in;

    // A requested length of zero behaves as a single tick so n_lat-1 never underflows.
    assign w_n_in = (delay_ticks == '0) ? CNT_WIDTH'(1) : delay_ticks;
    assign w_tick = (r_pre == PW'(PRESCALE - 1));
    assign w_last = (r_count == (r_n_lat - CNT_WIDTH'(1)));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_pre        <= '0;
            r_n_lat      <= '0;
            r_mode_lat   <= 1'b0;
            r_delay_done <= 1'b0;
            r_done_level <= 1'b0;
            r_busy       <= 1'b0;
`ifdef DELAY_REMAIN_EN
            r_remaining  <= '0;
`endif
        end else begin
            r_delay_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (en_delay) begin
                        r_state    <= S_RUN;
                        r_count    <= '0;
                        r_pre      <= '0;
                        r_n_lat    <= w_n_in;
                        r_mode_lat <= periodic;
                        r_busy     <= 1'b1;
`ifdef DELAY_REMAIN_EN
                        r_remaining <= w_n_in - CNT_WIDTH'(1);
`endif
                    end
                end
                S_RUN: begin
                    // Abort wins over a terminal tick on the same edge.
                    if (!en_delay) begin
                        r_state <= S_IDLE;
                        r_count <= '0;
                        r_pre   <= '0;
                        r_busy  <= 1'b0;
`ifdef DELAY_REMAIN_EN
                        r_remaining <= '0;
`endif
                    end else if (w_tick) begin
                        r_pre <= '0;
                        if (w_last) begin
                            r_delay_done <= 1'b1;
                            r_count      <= '0;
                            if (r_mode_lat) begin
                                r_n_lat <= w_n_in;
`ifdef DELAY_REMAIN_EN
                                r_remaining <= w_n_in - CNT_WIDTH'(1);
`endif
                            end else begin
                                r_state      <= S_DONE;
                                r_busy       <= 1'b0;
                                r_done_level <= 1'b1;
`ifdef DELAY_REMAIN_EN
                                r_remaining <= '0;
`endif
                            end
                        end else begin
                            r_count <= r_count + CNT_WIDTH'(1);
`ifdef DELAY_REMAIN_EN
                            r_remaining <= r_remaining - CNT_WIDTH'(1);
`endif
                        end
                    end else begin
                        r_pre <= r_pre + PW'(1);
                    end
                end
                S_DONE: begin
                    if (!en_delay) begin
                        r_state      <= S_IDLE;
                        r_done_level <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_busy       <= 1'b0;
                    r_done_level <= 1'b0;
                end
            endcase
        end
    end

    assign delay_done = r_delay_done;
    assign done_level = r_done_level;
    assign busy       = r_busy;
`ifdef DELAY_REMAIN_EN
    assign remaining  = r_remaining;
`endif

endmodule

// File: tb/tb_delay_timer.sv
// Randomised scoreboard bench for delay_timer: two instances (PRESCALE 1 and 4) share stimulus
// and are checked against a deadline-based reference model.
module tb_delay_timer;

    localparam int CW = 8;

    logic          clock;
    logic          reset_n;
    logic          en_delay;
    logic          periodic;
    logic [CW-1:0] delay_ticks;

    logic          dd [2];
    logic          dl [2];
    logic          bz [2];
    logic [CW-1:0] rm [2];

    delay_timer #(.CNT_WIDTH(CW), .PRESCALE(1)) u_dut_p1 (
        .clock(clock), .reset_n(reset_n), .en_delay(en_delay), .periodic(periodic),
        .delay_ticks(delay_ticks), .delay_done(dd[0]), .done_level(dl[0]),
`ifdef DELAY_REMAIN_EN
        .remaining(rm[0]),
`endif
        .busy(bz[0])
    );

    delay_timer #(.CNT_WIDTH(CW), .PRESCALE(4)) u_dut_p4 (
        .clock(clock), .reset_n(reset_n), .en_delay(en_delay), .periodic(periodic),
        .delay_ticks(delay_ticks), .delay_done(dd[1]), .done_level(dl[1]),
`ifdef DELAY_REMAIN_EN
        .remaining(rm[1]),
`endif
        .busy(bz[1])
    );

`ifndef DELAY_REMAIN_EN
    assign rm[0] = '0;
    assign rm[1] = '0;
`endif

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model: a run is an active flag plus the absolute edge of its next pulse.
    longint cyc;
    longint pre_k [2];
    bit     act   [2];
    bit     hold  [2];
    bit     mode  [2];
    longint ddl   [2];
    longint exp_q [2][$];

    initial begin
        pre_k[0] = 1;
        pre_k[1] = 4;
    end

    always @(posedge clock or negedge reset_n) begin
        longint n;
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                act[i]  = 1'b0;
                hold[i] = 1'b0;
                exp_q[i].delete();
            end
        end else begin
            cyc = cyc + 1;
            n = (delay_ticks == 0) ? 1 : longint'(delay_ticks);
            for (int i = 0; i < 2; i++) begin
                if (act[i]) begin
                    if (!en_delay) begin
                        act[i] = 1'b0;
                    end else if (cyc == ddl[i]) begin
                        exp_q[i].push_back(cyc);
                        if (mode[i]) ddl[i] = cyc + n * pre_k[i];
                        else begin
                            act[i]  = 1'b0;
                            hold[i] = 1'b1;
                        end
                    end
                end else if (hold[i]) begin
                    if (!en_delay) hold[i] = 1'b0;
                end else if (en_delay) begin
                    act[i]  = 1'b1;
                    mode[i] = periodic;
                    ddl[i]  = cyc + n * pre_k[i];
                end
            end
        end
    end

    int n_cmp;
    int n_bad;
    bit stim_done;

    task automatic chk(input string name, input int idx, input longint got, input longint want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s dut%0d @cyc %0d: got %0d want %0d", name, idx, cyc, got, want);
        end
    endtask

    // Monitor: pops the expected pulse whenever a DUT pulses, and checks status every cycle.
    initial begin
        longint want_rem;
        while (!stim_done) begin
            @(negedge clock or negedge reset_n);
            if (clock) #1;
            for (int i = 0; i < 2; i++) begin
                chk("busy", i, longint'(bz[i]), longint'(act[i]));
                chk("done_level", i, longint'(dl[i]), longint'(hold[i]));
`ifdef DELAY_REMAIN_EN
                want_rem = act[i] ? (ddl[i] - cyc - 1) / pre_k[i] : 0;
                chk("remaining", i, longint'(rm[i]), want_rem);
`else
                want_rem = 0;
`endif
                if (exp_q[i].size() > 0 && exp_q[i][0] < cyc) begin
                    chk("missed_pulse", i, cyc, exp_q[i][0]);
                    void'(exp_q[i].pop_front());
                end
                if (dd[i]) begin
                    if (exp_q[i].size() == 0) chk("spurious_pulse", i, cyc, -1);
                    else chk("pulse_cycle", i, cyc, exp_q[i].pop_front());
                end
            end
        end
        for (int i = 0; i < 2; i++) chk("leftover_pulses", i, longint'(exp_q[i].size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int k);
        repeat (k) @(posedge clock);
        #1;
    endtask

    // One run: en_delay sampled high on exactly `h` edges, then low for `gap` edges.
    task automatic run(input int n, input bit p, input int h, input int gap, input bit jitter);
        step(1);
        delay_ticks = CW'(n);
        periodic    = p;
        en_delay    = 1'b1;
        repeat (h) begin
            step(1);
            if (jitter && $urandom_range(0, 7) == 0) delay_ticks = CW'($urandom_range(0, 9));
            if (jitter && $urandom_range(0, 5) == 0) periodic = ~periodic;
        end
        en_delay = 1'b0;
        step(gap);
    endtask

    initial begin
        cyc         = 0;
        stim_done   = 1'b0;
        reset_n     = 1'b0;
        en_delay    = 1'b0;
        periodic    = 1'b0;
        delay_ticks = '0;
        repeat (4) begin
            step(1);
            en_delay = ~en_delay;
        end
        en_delay = 1'b0;
        step(1);
        reset_n = 1'b1;
        step(10);

        run(5, 1'b0, 25, 3, 1'b0);
        run(3, 1'b1, 13, 3, 1'b0);

        // periodic with a mid-run length change
        step(1);
        delay_ticks = CW'(3);
        periodic    = 1'b1;
        en_delay    = 1'b1;
        step(4);
        delay_ticks = CW'(2);
        step(16);
        en_delay = 1'b0;
        step(3);

        run(4, 1'b0, 3, 3, 1'b0);
        run(4, 1'b0, 4, 3, 1'b0);
        run(0, 1'b0, 6, 3, 1'b0);
        run(2, 1'b0, 12, 3, 1'b0);
        run(0, 1'b1, 10, 2, 1'b0);
        run(255, 1'b0, 1030, 3, 1'b0);

        // asynchronous reset in the middle of a run
        step(1);
        delay_ticks = CW'(5);
        periodic    = 1'b0;
        en_delay    = 1'b1;
        repeat (3) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #3;
        en_delay = 1'b0;
        step(3);
        reset_n = 1'b1;
        step(3);

        run(5, 1'b0, 8, 2, 1'b0);

        for (int k = 0; k < 60; k++) begin
            run($urandom_range(0, 12), 1'($urandom_range(0, 1)),
                $urandom_range(1, 45), $urandom_range(1, 3), 1'($urandom_range(0, 1)));
        end

        step(5);
        stim_done = 1'b1;
    end

endmodule
